// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Snoops a multiplexed, active-low seven-segment display bus (segment lines
// plus per-digit anode strobes). Each digit dwell is qualified by a stability
// counter, decoded back to a hex nibble and staged until every digit has been
// seen once. The completed frame is then offered over a valid/ready handshake.
//
// Timing from pins to frame:
//   pins stable from edge k -> capture at edge k+1+SETTLE_CYCLES
//   frame_valid rises one edge after the capture that completes the frame.

module seven_seg_capture #(
  parameter int N_DIGITS      = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_err,
  output logic [N_DIGITS-1:0]   digit_blank,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int CNT_W = 8;
  localparam int ZC_W  = $clog2(N_DIGITS + 1);

  // Counter saturates at SETTLE_CYCLES; capture fires on the step from
  // SETTLE_CYCLES-2 to SETTLE_CYCLES-1, which is passed exactly once per dwell.
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYCLES - 2);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // ---------------------------------------------------------------------------
  // Input synchronizers and previous-sample registers
  // ---------------------------------------------------------------------------
  logic [6:0]          seg_s1_q, seg_s2_q;
  logic [N_DIGITS-1:0] an_s1_q, an_s2_q;
  logic [6:0]          seg_prev_q;
  logic [N_DIGITS-1:0] an_prev_q;

  // Two-flop synchronizers; idle (all segments off, no anode) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  // Remember last cycle's synchronized bus so a dwell can be recognised as stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_prev_q <= SEG_BLANK;
      an_prev_q  <= '1;
    end else begin
      seg_prev_q <= seg_s2_q;
      an_prev_q  <= an_s2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Anode qualification: exactly one strobe low
  // ---------------------------------------------------------------------------
  logic [ZC_W-1:0]     zero_cnt;
  logic [N_DIGITS-1:0] low_mask;
  logic                an_valid;

  // Count low strobes and build the one-hot select of the active digit.
  always_comb begin
    zero_cnt = '0;
    low_mask = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_s2_q[i]) begin
        zero_cnt    = zero_cnt + ZC_W'(1);
        low_mask[i] = 1'b1;
      end
    end
    an_valid = (zero_cnt == ZC_W'(1));
  end

  // ---------------------------------------------------------------------------
  // Dwell stability counter and capture strobe
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             same_sample;
  logic             capture;

  // Any change or an unqualified anode restarts the dwell.
  always_comb begin
    same_sample = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);
    cnt_d       = '0;
    capture     = 1'b0;
    if (an_valid && same_sample) begin
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      capture = (cnt_q == CNT_CAP);
    end
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph decode (active-low segments, bit 0 = a .. bit 6 = g)
  // ---------------------------------------------------------------------------
  logic [3:0] dec_nib;
  logic       dec_err;
  logic       dec_blank;

  // Map a segment pattern back to its hex nibble; blank and unknown flagged.
  always_comb begin
    dec_nib   = 4'h0;
    dec_err   = 1'b0;
    dec_blank = 1'b0;
    case (seg_s2_q)
      7'h40:   dec_nib = 4'h0;
      7'h79:   dec_nib = 4'h1;
      7'h24:   dec_nib = 4'h2;
      7'h30:   dec_nib = 4'h3;
      7'h19:   dec_nib = 4'h4;
      7'h12:   dec_nib = 4'h5;
      7'h02:   dec_nib = 4'h6;
      7'h78:   dec_nib = 4'h7;
      7'h00:   dec_nib = 4'h8;
      7'h18:   dec_nib = 4'h9;
      7'h08:   dec_nib = 4'hA;
      7'h03:   dec_nib = 4'hB;
      7'h46:   dec_nib = 4'hC;
      7'h21:   dec_nib = 4'hD;
      7'h06:   dec_nib = 4'hE;
      7'h0E:   dec_nib = 4'hF;
      7'h7F:   dec_blank = 1'b1;
      default: dec_err   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Staging registers and seen mask
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] stg_nib_q, stg_nib_d;
  logic [N_DIGITS-1:0]   stg_err_q, stg_err_d;
  logic [N_DIGITS-1:0]   stg_blank_q, stg_blank_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic                  frame_done;

  // Completion is evaluated on the registered mask, so the frame is handed
  // off one edge after the capture that filled the last slot.
  assign frame_done = &seen_q;

  // Write the decoded glyph into the active digit's slot; last capture wins.
  always_comb begin
    stg_nib_d   = stg_nib_q;
    stg_err_d   = stg_err_q;
    stg_blank_d = stg_blank_q;
    seen_d      = frame_done ? '0 : seen_q;
    if (capture) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (low_mask[i]) begin
          stg_nib_d[4*i +: 4] = dec_nib;
          stg_err_d[i]        = dec_err;
          stg_blank_d[i]      = dec_blank;
          seen_d[i]           = 1'b1;
        end
      end
    end
  end

  // Staging and seen-mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_nib_q   <= '0;
      stg_err_q   <= '0;
      stg_blank_q <= '0;
      seen_q      <= '0;
    end else begin
      stg_nib_q   <= stg_nib_d;
      stg_err_q   <= stg_err_d;
      stg_blank_q <= stg_blank_d;
      seen_q      <= seen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output frame and handshake
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   digit_err_q, digit_err_d;
  logic [N_DIGITS-1:0]   digit_blank_q, digit_blank_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  out_free;

  // Load a completed frame when the slot is empty or being drained this
  // cycle; otherwise drop it and flag the overrun. Outputs hold while valid.
  always_comb begin
    out_free      = !frame_valid_q || frame_ready;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    digit_blank_d = digit_blank_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    if (frame_done && out_free) begin
      digits_d      = stg_nib_q;
      digit_err_d   = stg_err_q;
      digit_blank_d = stg_blank_q;
      frame_valid_d = 1'b1;
    end else if (frame_done) begin
      overrun_d = 1'b1;
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q      <= '0;
      digit_err_q   <= '0;
      digit_blank_q <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      digits_q      <= digits_d;
      digit_err_q   <= digit_err_d;
      digit_blank_q <= digit_blank_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign digit_blank = digit_blank_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: glyph table sweep plus directed sequences
// for dwell qualification, handshake, overrun and reset behaviour.

module tb_seven_seg_capture;

  localparam int N = 4;
  localparam int S = 4;

  logic         clk;
  logic         rst_n;
  logic [6:0]   seg_in;
  logic [N-1:0] an_in;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_err;
  logic [N-1:0] digit_blank;
  logic         frame_valid;
  logic         frame_ready;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] nib;
    logic       err;
    logic       blank;
  } glyph_t;

  glyph_t tbl[18];

  seven_seg_capture #(.N_DIGITS(N), .SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one digit on the bus at a negedge and hold it for cyc posedges.
  task automatic drive_digit(input int idx, input logic [6:0] seg, input int cyc);
    logic [N-1:0] one;
    @(negedge clk);
    one    = '1;
    one[idx] = 1'b0;
    an_in  = one;
    seg_in = seg;
    repeat (cyc) @(posedge clk);
  endtask

  // Called at a negedge with a frame pending: one-cycle ready pulse.
  task automatic consume(input string name);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ready = 1'b0;
    chk(name, 32'(frame_valid), 32'h0);
  endtask

  initial begin
    tbl[0]  = '{7'h40, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{7'h79, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{7'h24, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{7'h30, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{7'h19, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{7'h12, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{7'h02, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{7'h78, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{7'h00, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{7'h18, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{7'h08, 4'hA, 1'b0, 1'b0};
    tbl[11] = '{7'h03, 4'hB, 1'b0, 1'b0};
    tbl[12] = '{7'h46, 4'hC, 1'b0, 1'b0};
    tbl[13] = '{7'h21, 4'hD, 1'b0, 1'b0};
    tbl[14] = '{7'h06, 4'hE, 1'b0, 1'b0};
    tbl[15] = '{7'h0E, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{7'h7F, 4'h0, 1'b0, 1'b1};
    tbl[17] = '{7'h55, 4'h0, 1'b1, 1'b0};

    rst_n       = 1'b1;
    seg_in      = 7'h7F;
    an_in       = '1;
    frame_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset digits", 32'(digits), 32'h0);
    chk("reset err", 32'(digit_err), 32'h0);
    chk("reset blank", 32'(digit_blank), 32'h0);
    chk("reset valid", 32'(frame_valid), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;

    // Basic frame 6543 with exact hand-off latency on the last digit.
    drive_digit(0, 7'h30, 20);
    drive_digit(1, 7'h19, 20);
    drive_digit(2, 7'h12, 20);
    @(negedge clk);
    an_in  = 4'b0111;
    seg_in = 7'h02;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    chk("latency valid early", 32'(frame_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("latency valid rise", 32'(frame_valid), 32'h1);
    chk("frame1 digits", 32'(digits), 32'h6543);
    chk("frame1 err", 32'(digit_err), 32'h0);
    chk("frame1 blank", 32'(digit_blank), 32'h0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("frame1 held", 32'(frame_valid), 32'h1);
    chk("frame1 long dwell", 32'(overrun), 32'h0);
    consume("frame1 drop");

    // Digit 0 toggling faster than the settle window never captures.
    for (int k = 0; k < 10; k++) begin
      drive_digit(0, 7'h40, 2);
      drive_digit(0, 7'h79, 2);
    end
    drive_digit(1, 7'h79, 8);
    drive_digit(2, 7'h24, 8);
    drive_digit(3, 7'h30, 8);
    @(negedge clk);
    chk("toggle no frame", 32'(frame_valid), 32'h0);
    drive_digit(0, 7'h40, 8);
    @(negedge clk);
    chk("toggle then settle valid", 32'(frame_valid), 32'h1);
    chk("toggle then settle digits", 32'(digits), 32'h3210);
    consume("toggle drop");

    // Glyph sweep through digit 2.
    for (int e = 0; e < 18; e++) begin
      drive_digit(0, 7'h79, 8);
      drive_digit(1, 7'h24, 8);
      drive_digit(2, tbl[e].seg, 8);
      drive_digit(3, 7'h30, 8);
      @(negedge clk);
      chk($sformatf("sweep%0d valid", e), 32'(frame_valid), 32'h1);
      chk($sformatf("sweep%0d digits", e), 32'(digits), 32'({4'h3, tbl[e].nib, 4'h2, 4'h1}));
      chk($sformatf("sweep%0d err", e), 32'(digit_err), 32'({1'b0, tbl[e].err, 2'b00}));
      chk($sformatf("sweep%0d blank", e), 32'(digit_blank), 32'({1'b0, tbl[e].blank, 2'b00}));
      consume($sformatf("sweep%0d drop", e));
    end

    // Illegal anode patterns never capture; an anode glitch restarts the dwell.
    @(negedge clk);
    an_in  = 4'b1100;
    seg_in = 7'h40;
    repeat (50) @(posedge clk);
    @(negedge clk);
    an_in = 4'b1111;
    repeat (50) @(posedge clk);
    drive_digit(1, 7'h79, 8);
    drive_digit(2, 7'h24, 8);
    drive_digit(3, 7'h30, 8);
    @(negedge clk);
    chk("bad anode no frame", 32'(frame_valid), 32'h0);
    drive_digit(0, 7'h40, 3);
    @(negedge clk);
    an_in = 4'b1111;
    @(posedge clk);
    drive_digit(0, 7'h40, 3);
    drive_digit(1, 7'h79, 8);
    @(negedge clk);
    chk("glitch no frame", 32'(frame_valid), 32'h0);
    drive_digit(0, 7'h40, 8);
    @(negedge clk);
    chk("after glitch valid", 32'(frame_valid), 32'h1);
    chk("after glitch digits", 32'(digits), 32'h3210);
    consume("after glitch drop");

    // Overrun: frame A retained, B dropped, C loads on simultaneous drain.
    drive_digit(0, 7'h79, 8);
    drive_digit(1, 7'h24, 8);
    drive_digit(2, 7'h30, 8);
    drive_digit(3, 7'h19, 8);
    @(negedge clk);
    chk("frameA valid", 32'(frame_valid), 32'h1);
    chk("frameA digits", 32'(digits), 32'h4321);
    chk("frameA overrun", 32'(overrun), 32'h0);
    drive_digit(0, 7'h12, 8);
    drive_digit(1, 7'h02, 8);
    drive_digit(2, 7'h78, 8);
    drive_digit(3, 7'h00, 8);
    @(negedge clk);
    chk("frameB overrun", 32'(overrun), 32'h1);
    chk("frameB retained digits", 32'(digits), 32'h4321);
    chk("frameB retained valid", 32'(frame_valid), 32'h1);
    drive_digit(0, 7'h18, 8);
    drive_digit(1, 7'h08, 8);
    drive_digit(2, 7'h03, 8);
    @(negedge clk);
    an_in  = 4'b0111;
    seg_in = 7'h46;
    repeat (S + 2) @(posedge clk);
    @(negedge clk);
    chk("frameC pre digits", 32'(digits), 32'h4321);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ready = 1'b0;
    chk("frameC valid stays", 32'(frame_valid), 32'h1);
    chk("frameC digits", 32'(digits), 32'hCBA9);
    chk("frameC overrun sticky", 32'(overrun), 32'h1);

    // Reset mid-frame clears everything; the next frame needs all digits.
    drive_digit(0, 7'h21, 8);
    drive_digit(1, 7'h06, 8);
    @(negedge clk);
    an_in  = 4'b1011;
    seg_in = 7'h0E;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset digits", 32'(digits), 32'h0);
    chk("midreset valid", 32'(frame_valid), 32'h0);
    chk("midreset overrun", 32'(overrun), 32'h0);
    chk("midreset err", 32'(digit_err), 32'h0);
    chk("midreset blank", 32'(digit_blank), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_digit(2, 7'h0E, 8);
    drive_digit(3, 7'h40, 8);
    drive_digit(0, 7'h21, 8);
    @(negedge clk);
    chk("postreset partial", 32'(frame_valid), 32'h0);
    drive_digit(1, 7'h06, 8);
    @(negedge clk);
    chk("postreset valid", 32'(frame_valid), 32'h1);
    chk("postreset digits", 32'(digits), 32'h0FED);
    chk("postreset overrun", 32'(overrun), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
